// File: rtl/dual_issue_scheduler.sv
// Fetch buffer and dual-lane issue scheduler: a circular queue feeding decode lanes A/B,
// with lane B held on intra-pair hazards and per-lane immediate-format selects.
module dual_issue_scheduler #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            in_valid,
   input  logic [DATA_WIDTH-1:0] in_instr0,
   input  logic [DATA_WIDTH-1:0] in_instr1,
   output logic                  in_ready,
   input  logic                  stall,
   input  logic                  flush,
   output logic                  issueA_valid,
   output logic [DATA_WIDTH-1:0] instrA,
   output logic                  issueB_valid,
   output logic [DATA_WIDTH-1:0] instrB,
   output logic [5:0]            ImmSrc
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         head, tail;
   logic [CW-1:0]         count;

   logic [DATA_WIDTH-1:0] head_a, head_b;
   logic [6:0]            op_a, op_b;
   logic [4:0]            rd_a, rs1_b, rs2_b;
   logic                  a_ctrl, a_writes, b_uj, b_uses_rs2, hold_b;
   logic                  take_a, take_b, enq_ok;
   logic [CW-1:0]         n_enq, n_deq;

   function automatic logic [2:0] imm_sel(input logic [6:0] op);
      case (op)
         7'b0010011, 7'b0000011, 7'b1100111: imm_sel = 3'b000;
         7'b0100011:                         imm_sel = 3'b001;
         7'b1100011:                         imm_sel = 3'b010;
         7'b0110111, 7'b0010111:             imm_sel = 3'b011;
         7'b1101111:                         imm_sel = 3'b100;
         default:                            imm_sel = 3'b111;
      endcase
   endfunction

   // Free space is judged on count alone so in_ready never depends on this cycle's dequeue.
   assign in_ready = (count <= CW'(DEPTH - 2));
   assign enq_ok   = in_ready && !flush;
   assign n_enq    = enq_ok ? (CW'(in_valid[0]) + CW'(in_valid[1])) : '0;

   always_comb begin
      head_a     = mem[head];
      head_b     = mem[head + PW'(1)];
      op_a       = head_a[6:0];
      rd_a       = head_a[11:7];
      op_b       = head_b[6:0];
      rs1_b      = head_b[19:15];
      rs2_b      = head_b[24:20];
      a_ctrl     = (op_a == 7'b1100011) || (op_a == 7'b1101111) || (op_a == 7'b1100111);
      a_writes   = (op_a != 7'b0100011) && (op_a != 7'b1100011) && (rd_a != 5'd0);
      b_uj       = (op_b == 7'b0110111) || (op_b == 7'b0010111) || (op_b == 7'b1101111);
      b_uses_rs2 = (op_b == 7'b0110011) || (op_b == 7'b0100011) || (op_b == 7'b1100011);
      hold_b     = a_ctrl || (a_writes && ((!b_uj && (rs1_b == rd_a)) ||
                                           (b_uses_rs2 && (rs2_b == rd_a))));
      take_a     = !stall && (count != '0);
      take_b     = take_a && (count >= CW'(2)) && !hold_b;
      n_deq      = CW'(take_a) + CW'(take_b);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= NOP;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         issueA_valid <= 1'b0;
         issueB_valid <= 1'b0;
         instrA       <= NOP;
         instrB       <= NOP;
         ImmSrc       <= 6'b000000;
      end else if (flush) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         issueA_valid <= 1'b0;
         issueB_valid <= 1'b0;
         instrA       <= NOP;
         instrB       <= NOP;
         ImmSrc       <= 6'b000000;
      end else begin
         if (enq_ok) begin
            case (in_valid)
               2'b01: mem[tail] <= in_instr0;
               2'b10: mem[tail] <= in_instr1;
               2'b11: begin
                  mem[tail]          <= in_instr0;
                  mem[tail + PW'(1)] <= in_instr1;
               end
               default: ;
            endcase
            tail <= tail + PW'(n_enq);
         end
         head  <= head + PW'(n_deq);
         count <= count + n_enq - n_deq;
         if (!stall) begin
            issueA_valid <= take_a;
            instrA       <= take_a ? head_a : NOP;
            issueB_valid <= take_b;
            instrB       <= take_b ? head_b : NOP;
            ImmSrc       <= {take_a ? imm_sel(op_a) : 3'b000, take_b ? imm_sel(op_b) : 3'b000};
         end
      end
   end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard bench for dual_issue_scheduler: fetched instructions are queued in fetch order
// and popped as the lanes issue them, with lane validity and ImmSrc predicted by a small model.
module tb_dual_issue_scheduler;

   localparam int DEPTH = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  in_valid;
   logic [31:0] in_instr0, in_instr1;
   logic        in_ready;
   logic        stall, flush;
   logic        issueA_valid, issueB_valid;
   logic [31:0] instrA, instrB;
   logic [5:0]  ImmSrc;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] sb[$];
   logic        last_av, last_bv;
   logic [31:0] last_a, last_b;
   logic [5:0]  last_imm;

   dual_issue_scheduler #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr0(in_instr0), .in_instr1(in_instr1),
      .in_ready(in_ready), .stall(stall), .flush(flush), .issueA_valid(issueA_valid),
      .instrA(instrA), .issueB_valid(issueB_valid), .instrB(instrB), .ImmSrc(ImmSrc)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] imm_model(input logic [31:0] ins);
      logic [6:0] op;
      op = ins[6:0];
      if (op == 7'h13 || op == 7'h03 || op == 7'h67) return 3'd0;
      if (op == 7'h23) return 3'd1;
      if (op == 7'h63) return 3'd2;
      if (op == 7'h37 || op == 7'h17) return 3'd3;
      if (op == 7'h6f) return 3'd4;
      return 3'd7;
   endfunction

   function automatic bit held(input logic [31:0] a, input logic [31:0] b);
      logic [6:0] opa, opb;
      opa = a[6:0];
      opb = b[6:0];
      if (opa == 7'h63 || opa == 7'h6f || opa == 7'h67) return 1'b1;
      if (opa != 7'h23 && opa != 7'h63 && a[11:7] != 5'd0) begin
         if (!(opb == 7'h37 || opb == 7'h17 || opb == 7'h6f) && b[19:15] == a[11:7]) return 1'b1;
         if ((opb == 7'h33 || opb == 7'h23 || opb == 7'h63) && b[24:20] == a[11:7]) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic clear_model();
      sb.delete();
      last_av = 1'b0; last_bv = 1'b0;
      last_a = NOP; last_b = NOP; last_imm = 6'b0;
   endtask

   // Called at posedge+1; drives inputs, crosses one edge, then checks at posedge+1.
   task automatic tick(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic st, input logic fl);
      bit          exp_ready, enq, eav, ebv;
      logic [31:0] ea, eb;
      in_valid = v; in_instr0 = i0; in_instr1 = i1; stall = st; flush = fl;
      #1;
      exp_ready = (DEPTH - sb.size()) >= 2;
      check_val("in_ready", 32'(in_ready), 32'(exp_ready));
      enq = exp_ready && !fl;
      eav = sb.size() >= 1;
      ea  = NOP;
      if (eav) ea = sb[0];
      ebv = 1'b0;
      eb  = NOP;
      if (sb.size() >= 2) begin
         if (!held(sb[0], sb[1])) begin
            ebv = 1'b1;
            eb  = sb[1];
         end
      end
      @(posedge clk);
      #1;
      if (fl) begin
         clear_model();
      end else if (!st) begin
         last_av  = eav; last_a = ea; last_bv = ebv; last_b = eb;
         last_imm = {eav ? imm_model(ea) : 3'b000, ebv ? imm_model(eb) : 3'b000};
         if (eav) void'(sb.pop_front());
         if (ebv) void'(sb.pop_front());
      end
      check_val("issueA_valid", 32'(issueA_valid), 32'(last_av));
      check_val("instrA", instrA, last_a);
      check_val("issueB_valid", 32'(issueB_valid), 32'(last_bv));
      check_val("instrB", instrB, last_b);
      check_val("ImmSrc", 32'(ImmSrc), 32'(last_imm));
      if (enq) begin
         if (v[0]) sb.push_back(i0);
         if (v[1]) sb.push_back(i1);
      end
      in_valid = 2'b00;
      stall = 1'b0;
      flush = 1'b0;
   endtask

   localparam logic [31:0] ADDI1 = 32'h0050_0093;
   localparam logic [31:0] ADDI2 = 32'h0070_0113;
   localparam logic [31:0] ADD3  = 32'h0020_81B3;
   localparam logic [31:0] BEQ   = 32'h0020_8463;
   localparam logic [31:0] SW    = 32'h0020_A023;
   localparam logic [31:0] LUI5  = 32'h0001_22B7;
   localparam logic [31:0] JAL0  = 32'h0080_006F;
   localparam logic [31:0] ADDI0 = 32'h0010_0013;

   logic [31:0] pool [8];

   initial begin
      pool[0] = ADDI1; pool[1] = ADDI2; pool[2] = ADD3; pool[3] = BEQ;
      pool[4] = SW;    pool[5] = LUI5;  pool[6] = JAL0; pool[7] = ADDI0;
      clear_model();
      rst = 1'b1; in_valid = 2'b00; in_instr0 = '0; in_instr1 = '0; stall = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_a_valid", 32'(issueA_valid), 32'd0);
      check_val("rst_instrA", instrA, NOP);
      check_val("rst_imm", 32'(ImmSrc), 32'd0);
      check_val("rst_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;

      // independent pair issues together
      tick(2'b11, ADDI1, ADDI2, 1'b0, 1'b0);
      tick(2'b00, '0, '0, 1'b0, 1'b0);
      check_val("pair_A", instrA, ADDI1);
      check_val("pair_B", instrB, ADDI2);
      check_val("pair_imm", 32'(ImmSrc), 32'd0);

      // RAW on rs1 holds lane B
      tick(2'b11, ADDI1, ADD3, 1'b0, 1'b0);
      tick(2'b00, '0, '0, 1'b0, 1'b0);
      check_val("raw_B_held", 32'(issueB_valid), 32'd0);
      tick(2'b00, '0, '0, 1'b0, 1'b0);
      check_val("raw_A_next", instrA, ADD3);
      check_val("raw_immA", 32'(ImmSrc[5:3]), 32'd7);

      // branch in lane A holds lane B
      tick(2'b11, BEQ, SW, 1'b0, 1'b0);
      tick(2'b00, '0, '0, 1'b0, 1'b0);
      check_val("br_B_held", 32'(issueB_valid), 32'd0);
      tick(2'b00, '0, '0, 1'b0, 1'b0);
      check_val("br_A_sw", instrA, SW);
      check_val("br_immA", 32'(ImmSrc[5:3]), 32'd1);

      // fill under stall, then offer while full (dropped), then flush with stall and enqueue
      tick(2'b11, ADDI0, LUI5, 1'b1, 1'b0);
      tick(2'b01, ADDI2, '0, 1'b1, 1'b0);
      check_val("full_ready", 32'(in_ready), 32'd0);
      check_val("frozen_A", instrA, SW);
      tick(2'b11, JAL0, ADDI1, 1'b1, 1'b0);
      tick(2'b11, ADDI1, ADDI2, 1'b1, 1'b1);
      tick(2'b00, '0, '0, 1'b0, 1'b0);
      check_val("flush_empty_A", 32'(issueA_valid), 32'd0);
      check_val("flush_ready", 32'(in_ready), 32'd1);

      // mixed-slot stream through several pointer wraps
      for (int k = 0; k < 14; k++) begin
         logic [1:0] v;
         case ($urandom_range(0, 2))
            0: v = 2'b01;
            1: v = 2'b10;
            default: v = 2'b11;
         endcase
         tick(v, pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)], 1'b0, 1'b0);
      end
      for (int k = 0; k < 12 && sb.size() != 0; k++) tick(2'b00, '0, '0, 1'b0, 1'b0);
      check_val("drained", 32'(sb.size()), 32'd0);

      // asynchronous reset mid-stream, no clock edge
      tick(2'b11, ADDI0, ADDI0, 1'b0, 1'b0);
      tick(2'b11, ADDI2, ADDI1, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #2;
      check_val("arst_A_valid", 32'(issueA_valid), 32'd0);
      check_val("arst_B_valid", 32'(issueB_valid), 32'd0);
      check_val("arst_instrA", instrA, NOP);
      check_val("arst_ready", 32'(in_ready), 32'd1);
      #1 rst = 1'b0;
      clear_model();
      @(posedge clk);
      #1;
      tick(2'b11, ADDI1, ADDI2, 1'b0, 1'b0);
      tick(2'b00, '0, '0, 1'b0, 1'b0);
      check_val("post_rst_A", instrA, ADDI1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
